// File: rtl/count_arbiter_ctrl_pkg.sv
// Shared definitions for the round-robin counting arbiter.
// Holds the controller state enumeration and the default counter width.
package count_arbiter_ctrl_pkg;

  localparam int unsigned CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/count_arbiter_ctrl_count_core.sv
// count_core: CNT_W-bit up counter with synchronous clear and enable.
// Ports: clk, reset_n (async active-low), clr (clear to 0, wins over en),
//        en (increment by 1), q (registered count).
module count_core #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/count_arbiter_ctrl.sv
// count_arbiter_ctrl: two-requester round-robin arbiter that runs a shared
// counter from 0 up to the winner's terminal value, then pulses done.
// Ports: clk, reset_n (async active-low), req[1:0], term0/term1 (terminal
//        counts, latched at grant), gnt[1:0] (one-hot), q (count),
//        busy (not IDLE), done[1:0] (one-cycle completion pulse).
// Optional: define CNT_CTRL_ABORT_EN to add input abort, which ends a COUNT
//           run without a done pulse and still counts the requester as served.
module count_arbiter_ctrl
  import count_arbiter_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       req,
`ifdef CNT_CTRL_ABORT_EN
  input  logic             abort,
`endif
  input  logic [CNT_W-1:0] term0,
  input  logic [CNT_W-1:0] term1,
  output logic [1:0]       gnt,
  output logic [CNT_W-1:0] q,
  output logic             busy,
  output logic [1:0]       done
);

  state_t           state, state_nx;
  logic [1:0]       gnt_nx, done_nx;
  logic             busy_nx;
  logic [CNT_W-1:0] term_q, term_nx;
  logic             win, win_nx;    // requester currently granted
  logic             last, last_nx;  // requester served most recently
  logic             cnt_clr, cnt_en;

  count_core #(.CNT_W(CNT_W)) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .q       (q)
  );

  // State and registered outputs; last resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      gnt    <= '0;
      done   <= '0;
      busy   <= 1'b0;
      term_q <= '0;
      win    <= 1'b0;
      last   <= 1'b1;
    end else begin
      state  <= state_nx;
      gnt    <= gnt_nx;
      done   <= done_nx;
      busy   <= busy_nx;
      term_q <= term_nx;
      win    <= win_nx;
      last   <= last_nx;
    end
  end

  // Next-state, arbitration and counter control.
  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    done_nx  = '0;
    busy_nx  = busy;
    term_nx  = term_q;
    win_nx   = win;
    last_nx  = last;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        gnt_nx  = '0;
        busy_nx = 1'b0;
        if (req != 2'b00) begin
          // On a tie the requester not served last wins.
          win_nx   = (req == 2'b11) ? ~last : req[1];
          term_nx  = win_nx ? term1 : term0;
          gnt_nx   = win_nx ? 2'b10 : 2'b01;
          busy_nx  = 1'b1;
          state_nx = COUNT;
        end
      end

      COUNT: begin
`ifdef CNT_CTRL_ABORT_EN
        if (abort) begin
          state_nx = IDLE;
          gnt_nx   = '0;
          busy_nx  = 1'b0;
          cnt_clr  = 1'b1;
          last_nx  = win;
        end else
`endif
        if (q == term_q) begin
          // Hold q at the terminal value through DONE.
          state_nx = DONE;
          done_nx  = gnt;
          last_nx  = win;
        end else begin
          cnt_en = 1'b1;
        end
      end

      DONE: begin
        state_nx = IDLE;
        gnt_nx   = '0;
        busy_nx  = 1'b0;
        cnt_clr  = 1'b1;
      end

      default: begin
        state_nx = IDLE;
        gnt_nx   = '0;
        busy_nx  = 1'b0;
        cnt_clr  = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_count_arbiter_ctrl.sv
// Testbench for count_arbiter_ctrl: per-cycle expected outputs are queued
// when a request is driven and compared on each falling edge.
module tb_count_arbiter_ctrl;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [1:0]       req;
  logic [CNT_W-1:0] term0, term1;
  logic             abort;
  logic [1:0]       gnt;
  logic [CNT_W-1:0] q;
  logic             busy;
  logic [1:0]       done;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [8:0] sb[$];   // {gnt, q, busy, done} per cycle
  logic       last_srv;

  count_arbiter_ctrl #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
`ifdef CNT_CTRL_ABORT_EN
    .abort   (abort),
`endif
    .term0   (term0),
    .term1   (term1),
    .gnt     (gnt),
    .q       (q),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] ev(input logic [1:0] g, input logic [3:0] qv,
                                    input logic b, input logic [1:0] d);
    return {g, qv, b, d};
  endfunction

  // Monitor: compare against the next queued cycle, otherwise expect idle.
  always @(negedge clk) begin
    logic [8:0] e;
    if (reset_n) begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("trace", 16'({gnt, q, busy, done}), 16'(e));
      end else begin
        check("idle", 16'({gnt, q, busy, done}), 16'(0));
      end
    end
  end

  // Expected trace of one complete run, using a small round-robin model.
  task automatic push_run(input logic [1:0] r, input logic [3:0] t0, input logic [3:0] t1);
    logic       w;
    logic [3:0] t;
    logic [1:0] oh;
    w  = (r == 2'b11) ? ~last_srv : r[1];
    t  = w ? t1 : t0;
    oh = w ? 2'b10 : 2'b01;
    for (int i = 0; i <= int'(t); i++) sb.push_back(ev(oh, 4'(i), 1'b1, 2'b00));
    sb.push_back(ev(oh, t, 1'b1, oh));
    sb.push_back(ev(2'b00, 4'd0, 1'b0, 2'b00));
    last_srv = w;
  endtask

  task automatic wait_size(input int n);
    int c;
    c = 0;
    while (sb.size() > n && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    if (sb.size() > n) check("timeout", 16'(sb.size()), 16'(n));
  endtask

  task automatic start(input logic [1:0] r, input logic [3:0] t0, input logic [3:0] t1,
                       input int runs, input bit scramble);
    @(posedge clk); #1;
    req = r; term0 = t0; term1 = t1;
    sb.push_back(ev(2'b00, 4'd0, 1'b0, 2'b00));  // setup cycle, still IDLE
    for (int k = 0; k < runs; k++) push_run(r, t0, t1);
    if (scramble) begin
      @(posedge clk); #1;
      req   = 2'b00;
      term0 = 4'($urandom);
      term1 = 4'($urandom);
    end
    wait_size(1);
    req = 2'b00;
    wait_size(0);
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n = 1'b0; req = 2'b00; term0 = '0; term1 = '0; abort = 1'b0;
    last_srv = 1'b1;
    #12;
    check("rst_state", 16'({gnt, q, busy, done}), 16'(0));
    @(negedge clk); reset_n = 1'b1;

    // Tie held after reset: requester 0 then 1, one IDLE cycle between.
    start(2'b11, 4'd1, 4'd2, 2, 1'b0);
    // Single request, inputs changed mid-run are ignored.
    start(2'b01, 4'd3, 4'd0, 1, 1'b1);
    // term=0 completes two cycles after the request edge.
    start(2'b01, 4'd0, 4'd9, 1, 1'b0);
    // Maximum terminal value reaches 15 without wrapping.
    start(2'b10, 4'd2, 4'd15, 1, 1'b0);

    // Reset in the middle of a run.
    @(posedge clk); #1;
    req = 2'b01; term0 = 4'd9;
    sb.push_back(ev(2'b00, 4'd0, 1'b0, 2'b00));
    for (int i = 0; i <= 5; i++) sb.push_back(ev(2'b01, 4'(i), 1'b1, 2'b00));
    @(posedge clk); #1;
    req = 2'b00;
    for (int c = 0; c < 100 && sb.size() != 0; c++) begin
      @(negedge clk); #1;
    end
    check("q5_reached", 16'(sb.size()), 16'(0));
    reset_n = 1'b0;
    #1;
    check("async_rst", 16'({gnt, q, busy, done}), 16'(0));
    last_srv = 1'b1;
    @(negedge clk); #2;
    check("rst_hold", 16'({gnt, q, busy, done}), 16'(0));
    reset_n = 1'b1;
    start(2'b11, 4'd2, 4'd4, 1, 1'b0);   // pointer back to requester 0

`ifdef CNT_CTRL_ABORT_EN
    start(2'b10, 4'd0, 4'd3, 1, 1'b0);   // requester 1 served last
    @(posedge clk); #1;
    req = 2'b01; term0 = 4'd7;
    sb.push_back(ev(2'b00, 4'd0, 1'b0, 2'b00));
    for (int i = 0; i <= 2; i++) sb.push_back(ev(2'b01, 4'(i), 1'b1, 2'b00));
    sb.push_back(ev(2'b00, 4'd0, 1'b0, 2'b00));
    wait_size(2);
    req   = 2'b00;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    last_srv = 1'b0;                     // aborted requester counts as served
    wait_size(0);
    start(2'b11, 4'd1, 4'd1, 1, 1'b0);   // tie goes to requester 1
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
